memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 36 +++
 rtl/memory_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle for the three-port memory arbiter: requester handshakes and
// the single-port synchronous RAM connection.
interface memory_arbiter_if;
    logic        instruction_request;
    logic [15:0] instruction_address;
    logic        instruction_ack;
    logic        data_request;
    logic        data_write_enable;
    logic [15:0] data_address;
    logic [15:0] data_write_data;
    logic        data_ack;
    logic        video_request;
    logic [15:0] video_address;
    logic        video_ack;
    logic [15:0] read_data;
    logic [15:0] mem_address;
    logic        mem_write_enable;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    modport slave (
        input  instruction_request, instruction_address,
        input  data_request, data_write_enable, data_address, data_write_data,
        input  video_request, video_address, mem_read_data,
        output instruction_ack, data_ack, video_ack, read_data,
        output mem_address, mem_write_enable, mem_write_data
    );

    modport master (
        output instruction_request, instruction_address,
        output data_request, data_write_enable, data_address, data_write_data,
        output video_request, video_address, mem_read_data,
        input  instruction_ack, data_ack, video_ack, read_data,
        input  mem_address, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Three-port arbiter (video > data > instruction, with instruction starvation
// promotion) in front of a single-port synchronous RAM; one access per 2 cycles.
module memory_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    memory_arbiter_if.slave bus
);
    localparam int unsigned SC_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESPOND = 2'd2} state_t;
    typedef enum logic [1:0] {PORT_NONE = 2'd0, PORT_INSTR = 2'd1, PORT_DATA = 2'd2, PORT_VIDEO = 2'd3} port_t;

    state_t          state_r, state_s;
    port_t           winner_r, grant_s;
    logic [SC_W-1:0] starve_r, starve_s;
    logic [15:0]     grant_addr_s, mem_address_r, mem_address_s, wdata_r;
    logic            mem_we_r, mem_we_s;
    logic            ack_i_r, ack_d_r, ack_v_r, ack_i_s, ack_d_s, ack_v_s;
    logic            arb_s, i_eff_s, d_eff_s, v_eff_s;

    // Next state, arbitration, starvation counter and next registered outputs.
    always_comb begin
        state_s       = state_r;
        grant_s       = PORT_NONE;
        starve_s      = starve_r;
        grant_addr_s  = 16'h0000;
        arb_s         = (state_r == ST_IDLE) || (state_r == ST_RESPOND);
        // The port being acked still holds its request this cycle; ignore it.
        i_eff_s = bus.instruction_request && !((state_r == ST_RESPOND) && (winner_r == PORT_INSTR));
        d_eff_s = bus.data_request        && !((state_r == ST_RESPOND) && (winner_r == PORT_DATA));
        v_eff_s = bus.video_request       && !((state_r == ST_RESPOND) && (winner_r == PORT_VIDEO));

        case (state_r)
            ST_IDLE, ST_RESPOND: begin
                if (i_eff_s && (starve_r >= SC_MAX)) begin
                    grant_s = PORT_INSTR;
                end else if (v_eff_s) begin
                    grant_s = PORT_VIDEO;
                end else if (d_eff_s) begin
                    grant_s = PORT_DATA;
                end else if (i_eff_s) begin
                    grant_s = PORT_INSTR;
                end else begin
                    grant_s = PORT_NONE;
                end
                if (grant_s != PORT_NONE) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESPOND;
            default:   state_s = ST_IDLE;
        endcase

        if (!arb_s) begin
            starve_s = starve_r;
        end else if (!i_eff_s || (grant_s == PORT_INSTR)) begin
            starve_s = {SC_W{1'b0}};
        end else if (starve_r < SC_MAX) begin
            starve_s = starve_r + SC_ONE;
        end else begin
            starve_s = starve_r;
        end

        case (grant_s)
            PORT_INSTR: grant_addr_s = bus.instruction_address;
            PORT_DATA:  grant_addr_s = bus.data_address;
            PORT_VIDEO: grant_addr_s = bus.video_address;
            default:    grant_addr_s = 16'h0000;
        endcase

        mem_address_s = (grant_s != PORT_NONE) ? grant_addr_s : 16'h0000;
        mem_we_s      = (grant_s == PORT_DATA) && bus.data_write_enable;
        ack_i_s       = (state_r == ST_ACCESS) && (winner_r == PORT_INSTR);
        ack_d_s       = (state_r == ST_ACCESS) && (winner_r == PORT_DATA);
        ack_v_s       = (state_r == ST_ACCESS) && (winner_r == PORT_VIDEO);
    end

    // State, winner, starvation counter and registered bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            winner_r      <= PORT_NONE;
            starve_r      <= {SC_W{1'b0}};
            mem_address_r <= 16'h0000;
            mem_we_r      <= 1'b0;
            wdata_r       <= 16'h0000;
            ack_i_r       <= 1'b0;
            ack_d_r       <= 1'b0;
            ack_v_r       <= 1'b0;
        end else begin
            state_r       <= state_s;
            starve_r      <= starve_s;
            mem_address_r <= mem_address_s;
            mem_we_r      <= mem_we_s;
            ack_i_r       <= ack_i_s;
            ack_d_r       <= ack_d_s;
            ack_v_r       <= ack_v_s;
            if (grant_s != PORT_NONE) begin
                winner_r <= grant_s;
            end else begin
                winner_r <= winner_r;
            end
            if (grant_s == PORT_DATA) begin
                wdata_r <= bus.data_write_data;
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    assign bus.instruction_ack  = ack_i_r;
    assign bus.data_ack         = ack_d_r;
    assign bus.video_ack        = ack_v_r;
    assign bus.read_data        = bus.mem_read_data;
    assign bus.mem_address      = mem_address_r;
    assign bus.mem_write_enable = mem_we_r;
    assign bus.mem_write_data   = wdata_r;
endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter, checked against a
// transaction-timing reference model with its own golden memory image.
module tb_memory_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    memory_arbiter_if bus ();
    memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [15:0] ram  [0:65535];
    logic [15:0] gold [0:65535];

    // Behavioural single-port synchronous RAM.
    always @(posedge clock) begin
        if (bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_write_data;
        bus.mem_read_data <= ram[bus.mem_address];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge number of the last grant and what was granted.
    int          edge_n  = 0;
    bit          g_valid = 1'b0;
    int          g_edge  = -10;
    int          g_port  = 0;
    logic [15:0] g_addr  = 16'h0000;
    logic [15:0] g_wdata = 16'h0000;
    bit          g_we    = 1'b0;
    int          sc      = 0;
    int          mode    = 0;  // 0 finish only, 1 random traffic, 2 video/data re-request
    int          ack_cnt  [1:3];
    int          ack_edge [1:3];
    logic [15:0] last_rd  [1:3];
    bit          ack_cur  [1:3];
    bit          ack_prev [1:3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit get_req(input int p);
        case (p)
            1:       return bus.instruction_request;
            2:       return bus.data_request;
            3:       return bus.video_request;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_req(input int p, input bit on, input logic [15:0] a, input logic [15:0] wd, input bit we);
        case (p)
            1: begin bus.instruction_request = on; bus.instruction_address = a; end
            2: begin bus.data_request = on; bus.data_address = a; bus.data_write_data = wd; bus.data_write_enable = we; end
            3: begin bus.video_request = on; bus.video_address = a; end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        g_valid = 1'b0;
        sc      = 0;
        for (int p = 1; p <= 3; p++) begin ack_cur[p] = 1'b0; ack_prev[p] = 1'b0; end
    endtask

    // One rising edge as seen by the reference model.
    task automatic model_edge();
        int  excl, w;
        bit  ii, di, vi;
        edge_n++;
        if (g_valid && edge_n == g_edge + 1) begin
            if (g_we) gold[g_addr] = g_wdata;
        end else begin
            excl = (g_valid && edge_n == g_edge + 2) ? g_port : 0;
            ii = get_req(1) && excl != 1;
            di = get_req(2) && excl != 2;
            vi = get_req(3) && excl != 3;
            w = 0;
            if (ii && sc >= STARVE_LIMIT) w = 1;
            else if (vi) w = 3;
            else if (di) w = 2;
            else if (ii) w = 1;
            if (!ii || w == 1) sc = 0;
            else if (sc < STARVE_LIMIT) sc++;
            if (w != 0) begin
                g_valid = 1'b1;
                g_edge  = edge_n;
                g_port  = w;
                g_we    = (w == 2) && bus.data_write_enable;
                g_addr  = (w == 1) ? bus.instruction_address : (w == 2) ? bus.data_address : bus.video_address;
                if (w == 2) g_wdata = bus.data_write_data;
            end
        end
    endtask

    task automatic check_outputs();
        int         ep;
        logic [2:0] ev, gv;
        ep = (g_valid && edge_n == g_edge + 1) ? g_port : 0;
        ev = (ep == 0) ? 3'b000 : 3'(1 << (ep - 1));
        gv = {bus.video_ack, bus.data_ack, bus.instruction_ack};
        check_val("acks{v,d,i}", 32'(gv), 32'(ev));
        check_val("mem_write_enable", 32'(bus.mem_write_enable), 32'(g_valid && edge_n == g_edge && g_we));
        check_val("mem_address", 32'(bus.mem_address), (g_valid && edge_n == g_edge) ? 32'(g_addr) : 32'h0);
        if (ep != 0 && !g_we) check_val("read_data", 32'(bus.read_data), 32'(gold[g_addr]));
        if (g_valid && edge_n == g_edge && g_we) check_val("mem_write_data", 32'(bus.mem_write_data), 32'(g_wdata));
        for (int p = 1; p <= 3; p++) begin
            ack_cur[p] = gv[p-1];
            if (gv[p-1]) begin ack_cnt[p]++; ack_edge[p] = edge_n; last_rd[p] = bus.read_data; end
        end
    endtask

    // Requester behaviour at the falling edge.
    task automatic drive();
        for (int p = 1; p <= 3; p++) begin
            if (ack_prev[p]) begin
                if ((mode == 2 && p != 1) || (mode == 1 && $urandom_range(0, 1) == 1))
                    set_req(p, 1'b1, 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
                else
                    set_req(p, 1'b0, 16'h0000, 16'h0000, 1'b0);
            end else if (!get_req(p) && mode == 1 && $urandom_range(0, 3) == 0) begin
                set_req(p, 1'b1, 16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
            end
        end
        for (int p = 1; p <= 3; p++) ack_prev[p] = ack_cur[p];
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        @(negedge clock);
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int start, cnt0, idle_bad;
        for (int i = 0; i < 65536; i++) begin ram[i] = 16'h0000; gold[i] = 16'h0000; end
        for (int p = 1; p <= 3; p++) begin ack_cnt[p] = 0; ack_edge[p] = 0; last_rd[p] = 16'h0; end
        model_reset();
        reset = 1'b0;
        for (int p = 1; p <= 3; p++) set_req(p, 1'b0, 16'h0000, 16'h0000, 1'b0);
        #1;
        check_val("reset_acks", 32'({bus.video_ack, bus.data_ack, bus.instruction_ack}), 32'h0);
        check_val("reset_mem_we", 32'(bus.mem_write_enable), 32'h0);
        check_val("reset_mem_addr", 32'(bus.mem_address), 32'h0);
        check_val("reset_wdata", 32'(bus.mem_write_data), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Single instruction read.
        ram[16'h0010] = 16'hBEEF; gold[16'h0010] = 16'hBEEF;
        start = edge_n; cnt0 = ack_cnt[1];
        set_req(1, 1'b1, 16'h0010, 16'h0000, 1'b0);
        repeat (6) cycle();
        check_val("req037_latency", 32'(ack_edge[1] - start), 32'd2);
        check_val("req037_one_pulse", 32'(ack_cnt[1] - cnt0), 32'd1);
        check_val("req037_data", 32'(last_rd[1]), 32'hBEEF);

        // Data write, then read back through the instruction port.
        start = edge_n; cnt0 = ack_cnt[2];
        set_req(2, 1'b1, 16'h0200, 16'h1234, 1'b1);
        repeat (6) cycle();
        check_val("req038_ack_latency", 32'(ack_edge[2] - start), 32'd2);
        check_val("req038_one_ack", 32'(ack_cnt[2] - cnt0), 32'd1);
        set_req(1, 1'b1, 16'h0200, 16'h0000, 1'b0);
        repeat (6) cycle();
        check_val("req038_readback", 32'(last_rd[1]), 32'h1234);

        // Simultaneous requests: order video, data, instruction.
        start = edge_n;
        set_req(3, 1'b1, 16'h0003, 16'h0000, 1'b0);
        set_req(2, 1'b1, 16'h0004, 16'h5555, 1'b0);
        set_req(1, 1'b1, 16'h0005, 16'h0000, 1'b0);
        repeat (10) cycle();
        check_val("req039_video", 32'(ack_edge[3] - start), 32'd2);
        check_val("req039_data", 32'(ack_edge[2] - start), 32'd4);
        check_val("req039_instr", 32'(ack_edge[1] - start), 32'd6);

        // Starvation: video and data keep re-requesting.
        mode = 2; start = edge_n; cnt0 = ack_cnt[1];
        set_req(3, 1'b1, 16'h0006, 16'h0000, 1'b0);
        set_req(2, 1'b1, 16'h0007, 16'h0000, 1'b0);
        set_req(1, 1'b1, 16'h0008, 16'h0000, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (ack_cnt[1] != cnt0 && ack_edge[1] == edge_n)
                check_val("req040_starve_cleared", 32'(dut.starve_r), 32'h0);
        end
        check_val("req040_instr_latency", 32'(ack_edge[1] - start), 32'd10);
        mode = 0;
        repeat (10) cycle();

        // Random traffic against the model.
        mode = 1;
        repeat (400) cycle();
        mode = 0;
        repeat (12) cycle();

        // Reset during the ACCESS cycle of a write.
        cnt0 = ack_cnt[2];
        set_req(2, 1'b1, 16'h0300, 16'hA5A5, 1'b1);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        #2;
        reset = 1'b0;
        #1;
        check_val("req041_we_async", 32'(bus.mem_write_enable), 32'h0);
        check_val("req041_addr_async", 32'(bus.mem_address), 32'h0);
        model_reset();
        @(negedge clock);
        set_req(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(posedge clock);
        edge_n++;
        #1;
        check_val("req041_acks_in_reset", 32'({bus.video_ack, bus.data_ack, bus.instruction_ack}), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_val("req041_state_idle", 32'(dut.state_r), 32'h0);
        repeat (4) cycle();
        check_val("req041_no_ack", 32'(ack_cnt[2] - cnt0), 32'h0);
        check_val("req041_no_write", 32'(ram[16'h0300]), 32'h0);

        // Idle for ten cycles.
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.instruction_ack || bus.data_ack || bus.video_ack || bus.mem_write_enable || bus.mem_address != 16'h0)
                idle_bad++;
        end
        check_val("req042_idle_quiet", 32'(idle_bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
